// File: rtl/and_reg_filter.sv
// and_reg_filter: two-input registered logic combiner with optional
// input synchronizers, selectable Boolean function and stability filter.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset (clears every flop)
//   in0  - data input A (may be asynchronous when SYNC_STAGES > 0)
//   in1  - data input B
//   out  - registered result, driven straight from a flop
//
// Parameters:
//   SYNC_STAGES   - flops per input ahead of the function (0 = bypass)
//   OP            - 0 AND, 1 OR, 2 XOR, 3 NAND, anything else AND
//   FILTER_CYCLES - consecutive differing samples needed to move out
module and_reg_filter #(
    parameter int SYNC_STAGES   = 0,
    parameter int OP            = 0,
    parameter int FILTER_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic in0,
    input  logic in1,
    output logic out
);

    localparam int CW = $clog2(FILTER_CYCLES + 1);
    localparam logic [CW-1:0] CMAX = CW'(FILTER_CYCLES - 1);

    logic          s0;
    logic          s1;
    logic          f;
    logic [CW-1:0] cnt;

    generate
        if (SYNC_STAGES == 0) begin : g_bypass
            assign s0 = in0;
            assign s1 = in1;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] c0;
            logic [SYNC_STAGES-1:0] c1;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    c0 <= '0;
                    c1 <= '0;
                end else begin
                    c0[0] <= in0;
                    c1[0] <= in1;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        c0[i] <= c0[i-1];
                        c1[i] <= c1[i-1];
                    end
                end
            end

            assign s0 = c0[SYNC_STAGES-1];
            assign s1 = c1[SYNC_STAGES-1];
        end
    endgenerate

    always_comb begin
        f = s0 & s1;
        case (OP)
            1:       f = s0 | s1;
            2:       f = s0 ^ s1;
            3:       f = ~(s0 & s1);
            default: f = s0 & s1;
        endcase
    end

    // cnt tracks how many consecutive edges f has disagreed with out;
    // any agreeing sample throws the partial count away.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            out <= 1'b0;
        end else if (f == out) begin
            cnt <= '0;
        end else if (cnt == CMAX) begin
            out <= f;
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_and_reg_filter.sv
// tb_and_reg_filter: self-checking bench for and_reg_filter covering
// every OP, the stability filter and the synchronizer latency.
module tb_and_reg_filter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in0 = 1'b0;
    logic in1 = 1'b0;

    logic o_and, o_or, o_xor, o_nand, o_op5, o_f3, o_s2;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    and_reg_filter u_and (
        .clk(clk), .rst(rst), .in0(in0), .in1(in1), .out(o_and)
    );
    and_reg_filter #(.OP(1)) u_or (
        .clk(clk), .rst(rst), .in0(in0), .in1(in1), .out(o_or)
    );
    and_reg_filter #(.OP(2)) u_xor (
        .clk(clk), .rst(rst), .in0(in0), .in1(in1), .out(o_xor)
    );
    and_reg_filter #(.OP(3)) u_nand (
        .clk(clk), .rst(rst), .in0(in0), .in1(in1), .out(o_nand)
    );
    and_reg_filter #(.OP(5)) u_op5 (
        .clk(clk), .rst(rst), .in0(in0), .in1(in1), .out(o_op5)
    );
    and_reg_filter #(.FILTER_CYCLES(3)) u_f3 (
        .clk(clk), .rst(rst), .in0(in0), .in1(in1), .out(o_f3)
    );
    and_reg_filter #(.SYNC_STAGES(2), .OP(1)) u_s2 (
        .clk(clk), .rst(rst), .in0(in0), .in1(in1), .out(o_s2)
    );

    typedef struct {
        logic a;
        logic b;
        logic e_and;
        logic e_or;
        logic e_xor;
        logic e_nand;
    } vec_t;

    typedef struct {
        logic e_and;
        logic e_or;
        logic e_xor;
        logic e_nand;
    } exp_t;

    vec_t vecs[8];
    exp_t sbq[$];

    task automatic chk(input string nm, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %b expected %b (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    // advance to 2 ns after the next rising edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clean_reset();
        in0 = 1'b0;
        in1 = 1'b0;
        rst = 1'b1;
        #1;
        rst = 1'b0;
        tick();
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        exp_t e;

        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

        // reset state, all configurations
        #1;
        chk("rst_and", o_and, 1'b0);
        chk("rst_or", o_or, 1'b0);
        chk("rst_xor", o_xor, 1'b0);
        chk("rst_nand", o_nand, 1'b0);
        chk("rst_op5", o_op5, 1'b0);
        chk("rst_f3", o_f3, 1'b0);
        chk("rst_s2", o_s2, 1'b0);
        #11;
        rst = 1'b0;

        // NAND rises one latency after release; AND stays low
        tick();
        chk("nand_post_rst", o_nand, 1'b1);
        chk("and_post_rst", o_and, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("and_idle", o_and, 1'b0);
        end

        // table vectors through the scoreboard
        for (int i = 0; i < 8; i++) begin
            in0 = vecs[i].a;
            in1 = vecs[i].b;
            sbq.push_back('{vecs[i].e_and, vecs[i].e_or,
                            vecs[i].e_xor, vecs[i].e_nand});
            tick();
            e = sbq.pop_front();
            chk("vec_and", o_and, e.e_and);
            chk("vec_or", o_or, e.e_or);
            chk("vec_xor", o_xor, e.e_xor);
            chk("vec_nand", o_nand, e.e_nand);
            chk("vec_op5", o_op5, e.e_and);
        end

        // reset mid-operation with inputs held high
        in0 = 1'b1;
        in1 = 1'b1;
        tick();
        chk("mid_pre", o_and, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_and", o_and, 1'b0);
        chk("mid_rst_nand", o_nand, 1'b0);
        chk("mid_rst_or", o_or, 1'b0);
        #2;
        rst = 1'b0;
        tick();
        chk("mid_recover", o_and, 1'b1);

        // filter: short pulses never reach out
        clean_reset();
        in0 = 1'b1; in1 = 1'b1;
        tick(); chk("f3_p1a", o_f3, 1'b0);
        in0 = 1'b0; in1 = 1'b0;
        tick(); chk("f3_p1b", o_f3, 1'b0);
        in0 = 1'b1; in1 = 1'b1;
        tick(); chk("f3_p2a", o_f3, 1'b0);
        tick(); chk("f3_p2b", o_f3, 1'b0);
        in0 = 1'b0; in1 = 1'b0;
        tick(); chk("f3_p2c", o_f3, 1'b0);
        // held high: count restarted from zero
        in0 = 1'b1; in1 = 1'b1;
        tick(); chk("f3_h1", o_f3, 1'b0);
        tick(); chk("f3_h2", o_f3, 1'b0);
        tick(); chk("f3_h3", o_f3, 1'b1);
        // falling side also needs three samples
        in0 = 1'b0; in1 = 1'b1;
        tick(); chk("f3_l1", o_f3, 1'b1);
        tick(); chk("f3_l2", o_f3, 1'b1);
        tick(); chk("f3_l3", o_f3, 1'b0);

        // synchronizer latency, then reset clears the chains
        clean_reset();
        in0 = 1'b1;
        tick(); chk("s2_e1", o_s2, 1'b0);
        tick(); chk("s2_e2", o_s2, 1'b0);
        tick(); chk("s2_e3", o_s2, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        chk("s2_rst", o_s2, 1'b0);
        #2;
        rst = 1'b0;
        tick(); chk("s2_r1", o_s2, 1'b0);
        tick(); chk("s2_r2", o_s2, 1'b0);
        tick(); chk("s2_r3", o_s2, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/and_reg_filter.md
Name: and_reg_filter

Overview:
- Two-input registered logic combiner; integrates as the single-output leaf cell instantiated as `top` in gate-level/SDF-annotated simulation.
- Optional per-input synchronizer stages, a selectable 2-input Boolean function, and an optional glitch/stability filter feed a single registered output.
- Default configuration is one flop capturing `in0 AND in1` on each rising clock edge.

Parameters:
- SYNC_STAGES, 0, flops per input before the function (0 = bypass; legal 0..3).
- OP, 0, function select: 0 = AND, 1 = OR, 2 = XOR, 3 = NAND.
- FILTER_CYCLES, 1, consecutive edges the function result must differ from `out` before `out` updates (legal 1..15; 1 = no filtering).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- in0  input  1  data input A; asynchronous to clk when SYNC_STAGES > 0.
- in1  input  1  data input B.
- out  output 1  registered result; driven directly from a flop, no combinational path from any input.

Behaviour:
- Reset:
  - rst high immediately (asynchronously) clears all synchronizer flops, the filter counter and `out` to 0, for every OP value.
  - Deassertion is sampled at the next rising edge.
  - With OP = NAND, `out` rises to 1 one full latency after reset release.
- Input stage:
  - Each input passes through a chain of SYNC_STAGES flops: s0 = last stage of the in0 chain, s1 = last stage of the in1 chain.
  - When SYNC_STAGES = 0, s0/s1 are the raw inputs.
- Function:
  - f = OP(s0, s1), purely combinational; one bit wide.
  - OP values outside 0..3 behave as AND.
- Filter / output register:
  - A counter cnt of ceil(log2(FILTER_CYCLES+1)) bits is evaluated at each rising edge.
  - If f == out: cnt <= 0.
  - Else if cnt == FILTER_CYCLES-1: out <= f and cnt <= 0.
  - Else: cnt <= cnt+1.
  - FILTER_CYCLES = 1 therefore gives out <= f on every edge.
- Latency:
  - An input change stable from setup before edge N appears on `out` after edge N + SYNC_STAGES + FILTER_CYCLES − 1.
  - Default: visible after the first edge following the change.
- Glitch rejection:
  - A change of f shorter than FILTER_CYCLES consecutive samples never reaches `out`.
  - Counting restarts from 0 whenever f returns to the value of `out`.
- Simultaneous events:
  - rst overrides a clock edge.
  - Inputs changing exactly at a clock edge are timing violations.
  - In zero-delay RTL, such a change is captured at the following edge; the bench must not rely on either outcome.
- Reset mid-operation:
  - `out` drops to 0 within the same timestep regardless of filter state.
  - Any partial filter count is discarded.
- Gate-level constraints:
  - `out` must be glitch-free between clock edges.
  - All state elements must be edge-triggered flops with async clear; no latches.

Test Plan (defaults unless stated; clk period 10 ns, rising edges at 5, 15, 25 …):
1. rst = 1 from 0 to 12 ns, in0 = in1 = 0 → out = 0 from t = 0; still 0 after edges at 15, 25, 35, 45.
2. in0 = in1 = 1 at 52 ns → out = 1 after the edge at 55 ns; in1 = 0 at 78 ns → out = 0 after the edge at 85 ns.
3. in0 = in1 = 1 held, rst pulsed high 63–67 ns → out = 0 at 63 ns; returns to 1 after the edge at 75 ns.
4. OP = 2 (XOR): (in0, in1) sequence 0/0 → 1/0 → 1/1, each held one cycle → out sequence 0 → 1 → 0, each one edge after its input.
5. FILTER_CYCLES = 3, in0 = in1 = 1 pulsed for one cycle (52–62 ns) → out stays 0; then held from 102 ns → out = 1 after the edge at 125 ns.
6. SYNC_STAGES = 2, OP = 1 (OR), in0 rises at 52 ns → out = 1 after the edge at 75 ns; rst asserted at 90 ns → out = 0 and synchronizer chains = 0.
